// File: rtl/apb_fifo_slave_if.sv
// APB bus signals between APB_Master and the FIFO slave on one PSELx slot.
interface apb_fifo_slave_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB slave with a DEPTH x DATA_WIDTH FIFO, status/control/threshold registers,
// a level threshold interrupt and exactly one wait state per transfer.
module apb_fifo_slave #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_fifo_slave_if.slave       bus,
    output logic                  irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] REG_DATA   = 2'b00;
    localparam logic [1:0] REG_STATUS = 2'b01;
    localparam logic [1:0] REG_THRESH = 2'b11;
    localparam logic [1:0] REG_CTRL   = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [7:0]            count8;
    logic                  ovf;
    logic                  udf;
    logic [7:0]            thresh;

    logic                  access1;
    logic                  complete;
    logic [1:0]            sel;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic [31:0]           rdata_nxt;
    logic                  unused_bits;

    assign sel      = bus.PADDR[3:2];
    assign access1  = bus.PSEL & bus.PENABLE & ~bus.PREADY;
    assign complete = bus.PSEL & bus.PENABLE & bus.PREADY;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign count8   = 8'(count);
    assign do_push  = complete & bus.PWRITE & (sel == REG_DATA) & ~full;

    assign unused_bits = ^{bus.PADDR[31:4], bus.PADDR[1:0], bus.PWDATA};

    // Read data is captured in the first access cycle so it is presented
    // alongside PREADY; the pop itself lands on the completing edge.
    always_comb begin
        rdata_nxt = '0;
        case (sel)
            REG_DATA:   if (!empty) rdata_nxt = 32'(mem[rd_ptr]);
            REG_STATUS: rdata_nxt = {16'b0, count8, 4'b0, udf, ovf, full, empty};
            REG_THRESH: rdata_nxt = {24'b0, thresh};
            default:    rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET && do_push)
            mem[wr_ptr] <= bus.PWDATA[DATA_WIDTH-1:0];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            bus.PREADY <= 1'b0;
            bus.PRDATA <= '0;
            irq        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
            thresh     <= '0;
        end else begin
            bus.PREADY <= access1;
            bus.PRDATA <= (access1 && !bus.PWRITE) ? rdata_nxt : '0;
            irq        <= (thresh != '0) && (count8 >= thresh);

            if (complete && bus.PWRITE) begin
                case (sel)
                    REG_DATA: begin
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count + 1'b1;
                        end
                    end
                    REG_CTRL: begin
                        if (bus.PWDATA[0]) begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            count  <= '0;
                        end
                        if (bus.PWDATA[1]) begin
                            ovf <= 1'b0;
                            udf <= 1'b0;
                        end
                    end
                    REG_THRESH: thresh <= bus.PWDATA[7:0];
                    default: ;
                endcase
            end

            if (complete && !bus.PWRITE && (sel == REG_DATA)) begin
                if (empty) begin
                    udf <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/apb_fifo_slave.md
Name: apb_fifo_slave

Overview:
- APB slave peripheral that sits directly downstream of APB_Master on one PSELx/PRDATAx/PREADYx slot.
- Holds a parameterised FIFO that the CPU pushes to and pops from over APB, plus status, control and threshold registers.
- Drives a level interrupt when the FIFO fill level reaches a programmable threshold.
- Inserts exactly one wait state per transfer, which exercises the master's PREADY handling.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, range 2..128.
- DATA_WIDTH, 8, FIFO entry width; range 1..32.

Ports:
- PCLK  in  1  APB clock; all state updates on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PADDR  in  32  address; only PADDR[3:2] is decoded, all other bits are ignored.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only while PREADY=1.
- PREADY  out  1  transfer complete.
- irq  out  1  threshold interrupt, level.

Behaviour:
- Reset: PCLK is the single clock. PRESET is synchronous and active-high. While PRESET=1 at a rising edge:
  - PREADY=0, PRDATA=0, irq=0.
  - FIFO is empty: count=0, read and write pointers 0.
  - Overflow/underflow flags=0, THRESH=0.
- Reset mid-transfer: the transfer is abandoned with no side effect, and PREADY stays 0 until a new access phase starts.
- Handshake:
  - Access cycle 1 (PSEL=1, PENABLE=1, PREADY=0): the slave registers PREADY=1 for the next cycle.
  - Access cycle 2: PREADY=1. The transfer completes on the rising edge where PSEL&PENABLE&PREADY=1.
  - PREADY falls to 0 the following cycle and is never high for two consecutive cycles.
  - Setup phase (PSEL=1, PENABLE=0) and PSEL=0 cause no side effects.
- Timing: PRDATA is registered together with PREADY and is 0 whenever PREADY=0. Every push, pop or register write takes effect on the completing edge.
- Register map (PADDR[3:2]):
  - 00 DATA. Write pushes PWDATA[DATA_WIDTH-1:0]. Read returns the head entry zero-extended to 32 bits and pops it.
  - 01 STATUS, read-only. bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bits[15:8] count, other bits 0. Writes are ignored.
  - 10 CTRL, write-only, reads 0. bit0=1 flushes the FIFO (pointers and count to 0, contents unchanged). bit1=1 clears both sticky flags. Both actions happen in the same cycle if both bits are set.
  - 11 THRESH, read/write, bits[7:0]; upper bits read 0.
- Full: a DATA write is dropped, FIFO is unchanged, overflow is set. PREADY still completes normally (no PSLVERR).
- Empty: a DATA read returns PRDATA=0, pointers are unchanged, underflow is set.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Only one push or pop can occur per completed transfer, so no simultaneous push/pop case exists.
- irq: registered, irq = (THRESH!=0) && (count >= THRESH). It updates one cycle after count or THRESH changes and is cleared by draining the FIFO or by writing THRESH=0.
- A DATA read returns the head entry as it was before the pop.

Test Plan:
- Reset and timing:
  - Apply PRESET for 2 cycles, then read STATUS → 0x0000_0001 (empty), irq=0, PREADY=0 outside transfers.
  - Check every transfer shows exactly one wait cycle: PREADY high 2 cycles after the setup phase, for 1 cycle.
- Ordering: write DATA 0x0A, 0x0B, 0x0C (addr 0x1000_0000), read STATUS → count=3. Read DATA three times → 0x0A, 0x0B, 0x0C, then STATUS=0x0000_0001.
- Full/overflow with pointer wrap (DEPTH=8):
  - Push 0x10..0x17 → STATUS=0x0000_0802. A 9th write of 0xFF → STATUS=0x0000_0806 and FIFO unchanged.
  - Pop all → 0x10..0x17 in order.
  - Push 0x20..0x24, pop 5 → correct data across the pointer wrap.
- Underflow and flag clear: read DATA while empty → PRDATA=0, STATUS bit3=1. Write CTRL=0x2 → STATUS=0x0000_0001.
- Threshold: write THRESH=3 (addr 0x1000_000C).
  - Push 2 → irq=0. Push a 3rd → irq=1 one cycle after completion. Pop 1 → irq=0.
  - Read THRESH → 0x0000_0003.
- Flush and mid-transfer reset:
  - Push 4, write CTRL=0x1 → STATUS=0x0000_0001, irq=0.
  - Assert PRESET during an access-phase DATA write → no push occurs, STATUS=0x0000_0001 after reset, PREADY=0.
